// File: rtl/light_pkg.sv
// Shared cell encoding for the light row: the stored light state and its raw codes.
// The code 2'b11 is reserved and is never written into a cell.
package light_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'b00,
    RED   = 2'b01,
    GREEN = 2'b10
  } light_t;

  localparam logic [1:0] CODE_OFF   = 2'b00;
  localparam logic [1:0] CODE_RED   = 2'b01;
  localparam logic [1:0] CODE_GREEN = 2'b10;
  localparam logic [1:0] CODE_BAD   = 2'b11;

endpackage

// File: rtl/light_cell.sv
// One light cell: state register plus next-state mux (hold, shift-in, spawn, clear).
// One cycle: the chosen source appears on q right after the clock edge.
module light_cell
  import light_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       shift_left,
  input  logic       shift_right,
  input  logic [1:0] left_src,
  input  logic [1:0] right_src,
  input  logic       spawn_hit,
  input  logic [1:0] spawn_code,
  output logic [1:0] q
);

  light_t cur;
  light_t nxt;

  // Spawn is applied last so it overwrites whatever a shift brought in.
  always_comb begin
    nxt = cur;
    if (clear) begin
      nxt = OFF;
    end else begin
      if (shift_left) begin
        nxt = light_t'(left_src);
      end else if (shift_right) begin
        nxt = light_t'(right_src);
      end
      if (spawn_hit) begin
        nxt = light_t'(spawn_code);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur <= OFF;
    end else begin
      cur <= nxt;
    end
  end

  assign q = cur;

endmodule

// File: rtl/light_row.sv
// Row of N light cells moved by rising edges of mv_left/mv_right, with spawn, clear and exit counters.
// One cycle from the sampled key edge to the shifted row on lights; simultaneous edges cancel.
module light_row
  import light_pkg::*;
#(
  parameter int N     = 8,
  parameter int WRAP  = 0,
  parameter int CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 mv_left,
  input  logic                 mv_right,
  input  logic                 clear,
  input  logic                 spawn_en,
  input  logic [1:0]           spawn_color,
  input  logic [$clog2(N)-1:0] spawn_pos,
  output logic [2*N-1:0]       lights,
  output logic [CNT_W-1:0]     exit_left_cnt,
  output logic [CNT_W-1:0]     exit_right_cnt
);

  localparam int   PW      = $clog2(N);
  localparam logic WRAP_ON = (WRAP != 0);

  logic       hist_l;
  logic       hist_r;
  logic       rise_l;
  logic       rise_r;
  logic       do_left;
  logic       do_right;
  logic       pos_ok;
  logic       spawn_ok;
  logic       left_exit;
  logic       right_exit;
  logic [1:0] left_fill;
  logic [1:0] right_fill;
  logic [1:0] cell_q [N];

  // Histories reset high so a key held through reset is not seen as a fresh press.
  always_ff @(posedge clock) begin
    if (reset) begin
      hist_l <= 1'b1;
      hist_r <= 1'b1;
    end else begin
      hist_l <= mv_left;
      hist_r <= mv_right;
    end
  end

  assign rise_l   = mv_left  & ~hist_l;
  assign rise_r   = mv_right & ~hist_r;
  assign do_left  = rise_l & ~rise_r & ~clear;
  assign do_right = rise_r & ~rise_l & ~clear;

  assign pos_ok   = int'(spawn_pos) < N;
  assign spawn_ok = spawn_en & ~clear & pos_ok & (spawn_color != CODE_BAD);

  assign left_fill  = WRAP_ON ? cell_q[N-1] : CODE_OFF;
  assign right_fill = WRAP_ON ? cell_q[0]   : CODE_OFF;

  assign left_exit  = do_left  & ~WRAP_ON & (cell_q[N-1] != CODE_OFF);
  assign right_exit = do_right & ~WRAP_ON & (cell_q[0]   != CODE_OFF);

  for (genvar gi = 0; gi < N; gi++) begin : g_cell
    logic [1:0] from_lower;
    logic [1:0] from_upper;

    if (gi == 0) begin : g_lo
      assign from_lower = left_fill;
    end else begin : g_lo
      assign from_lower = cell_q[gi-1];
    end

    if (gi == N-1) begin : g_hi
      assign from_upper = right_fill;
    end else begin : g_hi
      assign from_upper = cell_q[gi+1];
    end

    light_cell u_cell (
      .clock       (clock),
      .reset       (reset),
      .clear       (clear),
      .shift_left  (do_left),
      .shift_right (do_right),
      .left_src    (from_lower),
      .right_src   (from_upper),
      .spawn_hit   (spawn_ok && (spawn_pos == PW'(gi))),
      .spawn_code  (spawn_color),
      .q           (cell_q[gi])
    );

    assign lights[2*gi +: 2] = cell_q[gi];
  end

  // Exit counters stick at all-ones rather than wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      exit_left_cnt  <= '0;
      exit_right_cnt <= '0;
    end else begin
      if (left_exit && (exit_left_cnt != '1)) begin
        exit_left_cnt <= exit_left_cnt + CNT_W'(1);
      end
      if (right_exit && (exit_right_cnt != '1)) begin
        exit_right_cnt <= exit_right_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_light_row.sv
// Three light_row instances (N=4): plain, wrapping, and 2-bit counters, all sharing one input stream.
// Each is compared with an array-based model of the row.
module tb_light_row;

  localparam int N = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       mv_left;
  logic       mv_right;
  logic       clear;
  logic       spawn_en;
  logic [1:0] spawn_color;
  logic [1:0] spawn_pos;

  logic [7:0] l0, l1, l2;
  logic [7:0] cl0, cr0, cl1, cr1;
  logic [1:0] cl2, cr2;
  logic [7:0] lt [3];
  logic [7:0] cl [3];
  logic [7:0] cr [3];

  int n_cmp = 0;
  int n_err = 0;

  // Model state, one row per instance
  int m [3][N];
  int mcl [3];
  int mcr [3];
  bit pl [3];
  bit pr [3];
  int wrapv [3] = '{0, 1, 0};
  int cmax  [3] = '{255, 255, 3};

  always #5 clock = ~clock;

  light_row #(.N(4), .WRAP(0), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .mv_left(mv_left), .mv_right(mv_right), .clear(clear),
    .spawn_en(spawn_en), .spawn_color(spawn_color), .spawn_pos(spawn_pos),
    .lights(l0), .exit_left_cnt(cl0), .exit_right_cnt(cr0));

  light_row #(.N(4), .WRAP(1), .CNT_W(8)) dut_w (
    .clock(clock), .reset(reset), .mv_left(mv_left), .mv_right(mv_right), .clear(clear),
    .spawn_en(spawn_en), .spawn_color(spawn_color), .spawn_pos(spawn_pos),
    .lights(l1), .exit_left_cnt(cl1), .exit_right_cnt(cr1));

  light_row #(.N(4), .WRAP(0), .CNT_W(2)) dut_c (
    .clock(clock), .reset(reset), .mv_left(mv_left), .mv_right(mv_right), .clear(clear),
    .spawn_en(spawn_en), .spawn_color(spawn_color), .spawn_pos(spawn_pos),
    .lights(l2), .exit_left_cnt(cl2), .exit_right_cnt(cr2));

  assign lt[0] = l0;
  assign lt[1] = l1;
  assign lt[2] = l2;
  assign cl[0] = cl0;
  assign cl[1] = cl1;
  assign cl[2] = {6'b0, cl2};
  assign cr[0] = cr0;
  assign cr[1] = cr1;
  assign cr[2] = {6'b0, cr2};

  function automatic logic [7:0] mlights(int k);
    logic [7:0] r;
    for (int i = 0; i < N; i++) r[2*i +: 2] = 2'(m[k][i]);
    return r;
  endfunction

  // Row model: lights as a list of cells; a move drops the cell at one end and
  // inserts either that same light (wrap) or an empty cell at the other end.
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        for (int i = 0; i < N; i++) m[k][i] = 0;
        mcl[k] = 0; mcr[k] = 0; pl[k] = 1; pr[k] = 1;
      end else begin
        bit el, er;
        int out;
        el = mv_left && !pl[k];
        er = mv_right && !pr[k];
        pl[k] = mv_left;
        pr[k] = mv_right;
        if (clear) begin
          for (int i = 0; i < N; i++) m[k][i] = 0;
        end else begin
          if (el && !er) begin
            out = m[k][N-1];
            for (int i = N-1; i > 0; i--) m[k][i] = m[k][i-1];
            m[k][0] = wrapv[k] ? out : 0;
            if (!wrapv[k] && out != 0 && mcl[k] < cmax[k]) mcl[k]++;
          end else if (er && !el) begin
            out = m[k][0];
            for (int i = 0; i < N-1; i++) m[k][i] = m[k][i+1];
            m[k][N-1] = wrapv[k] ? out : 0;
            if (!wrapv[k] && out != 0 && mcr[k] < cmax[k]) mcr[k]++;
          end
          if (spawn_en && spawn_pos < N && spawn_color != 2'b11) m[k][spawn_pos] = spawn_color;
        end
      end
    end
  endtask

  task automatic drv(input logic r, input logic l, input logic rt, input logic c,
                     input logic se, input logic [1:0] col, input logic [1:0] pos);
    reset = r; mv_left = l; mv_right = rt; clear = c;
    spawn_en = se; spawn_color = col; spawn_pos = pos;
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    drv(1, 1, 0, 0, 1, 2'b01, 2'd0);
    drv(1, 1, 0, 0, 1, 2'b01, 2'd0);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (lt[k] !== 8'h00) begin n_err++; $display("FAIL reset_lights inst%0d got %h want 00", k, lt[k]); end
      n_cmp++;
      if (cl[k] !== 8'h00 || cr[k] !== 8'h00) begin
        n_err++; $display("FAIL reset_cnt inst%0d got %0d/%0d want 0/0", k, cl[k], cr[k]);
      end
    end
    drv(0, 1, 0, 0, 1, 2'b01, 2'd0);
    drv(0, 1, 0, 0, 0, 2'b00, 2'd0);
    n_cmp++;
    if (lt[0] !== 8'h01) begin n_err++; $display("FAIL held_key_no_shift got %h want 01", lt[0]); end
    drv(0, 0, 0, 0, 0, 2'b00, 2'd0);
  endtask

  task automatic test_single_move();
    drv(1, 0, 0, 0, 0, 2'b00, 2'd0);
    drv(0, 0, 0, 0, 1, 2'b01, 2'd0);
    drv(0, 1, 0, 0, 0, 2'b00, 2'd0);
    n_cmp++;
    if (lt[0] !== 8'h04) begin n_err++; $display("FAIL move_left_lights got %h want 04", lt[0]); end
    n_cmp++;
    if (cl[0] !== 8'd0 || cr[0] !== 8'd0) begin
      n_err++; $display("FAIL move_left_cnt got %0d/%0d want 0/0", cl[0], cr[0]);
    end
    drv(0, 0, 0, 0, 0, 2'b00, 2'd0);
  endtask

  task automatic test_hold();
    drv(1, 0, 0, 0, 0, 2'b00, 2'd0);
    drv(0, 0, 0, 0, 1, 2'b10, 2'd3);
    drv(0, 0, 0, 0, 1, 2'b01, 2'd0);
    for (int c = 0; c < 10; c++) begin
      drv(0, 1, 0, 0, 0, 2'b00, 2'd0);
      n_cmp++;
      if (lt[0] !== 8'h04 || cl[0] !== 8'd1) begin
        n_err++; $display("FAIL hold_cycle%0d got %h cnt %0d want 04 cnt 1", c, lt[0], cl[0]);
      end
    end
    drv(0, 0, 0, 0, 0, 2'b00, 2'd0);
  endtask

  task automatic test_wrap();
    drv(1, 0, 0, 0, 0, 2'b00, 2'd0);
    drv(0, 0, 0, 0, 1, 2'b01, 2'd3);
    drv(0, 0, 0, 0, 1, 2'b10, 2'd0);
    drv(0, 0, 1, 0, 0, 2'b00, 2'd0);
    n_cmp++;
    if (lt[1] !== 8'h90) begin n_err++; $display("FAIL wrap_right_lights got %h want 90", lt[1]); end
    n_cmp++;
    if (cl[1] !== 8'd0 || cr[1] !== 8'd0) begin
      n_err++; $display("FAIL wrap_cnt got %0d/%0d want 0/0", cl[1], cr[1]);
    end
    n_cmp++;
    if (lt[0] !== 8'h10 || cr[0] !== 8'd1) begin
      n_err++; $display("FAIL nowrap_right got %h cnt %0d want 10 cnt 1", lt[0], cr[0]);
    end
    drv(0, 0, 0, 0, 0, 2'b00, 2'd0);
  endtask

  task automatic test_cancel();
    drv(1, 0, 0, 0, 0, 2'b00, 2'd0);
    drv(0, 0, 0, 0, 1, 2'b01, 2'd1);
    drv(0, 0, 0, 0, 1, 2'b10, 2'd2);
    drv(0, 1, 1, 0, 0, 2'b00, 2'd0);
    n_cmp++;
    if (lt[0] !== 8'h24 || cl[0] !== 8'd0 || cr[0] !== 8'd0) begin
      n_err++; $display("FAIL cancel got %h cnt %0d/%0d want 24 cnt 0/0", lt[0], cl[0], cr[0]);
    end
    drv(0, 0, 0, 0, 0, 2'b00, 2'd0);
    drv(0, 1, 0, 0, 0, 2'b00, 2'd0);
    n_cmp++;
    if (lt[0] !== 8'h90) begin n_err++; $display("FAIL after_cancel got %h want 90", lt[0]); end
    drv(0, 0, 0, 0, 0, 2'b00, 2'd0);
  endtask

  task automatic test_saturate();
    drv(1, 0, 0, 0, 0, 2'b00, 2'd0);
    for (int j = 0; j < 5; j++) begin
      drv(0, 0, 0, 0, 1, 2'b01, 2'd3);
      drv(0, 1, 0, 0, 0, 2'b00, 2'd0);
      drv(0, 0, 0, 0, 0, 2'b00, 2'd0);
      n_cmp++;
      if (cl[2] !== 8'((j + 1 > 3) ? 3 : j + 1)) begin
        n_err++; $display("FAIL sat_cnt step%0d got %0d want %0d", j, cl[2], (j + 1 > 3) ? 3 : j + 1);
      end
    end
    n_cmp++;
    if (cl[0] !== 8'd5) begin n_err++; $display("FAIL wide_cnt got %0d want 5", cl[0]); end
  endtask

  task automatic test_clear();
    drv(1, 0, 0, 0, 0, 2'b00, 2'd0);
    drv(0, 0, 0, 0, 1, 2'b10, 2'd3);
    drv(0, 1, 0, 1, 1, 2'b01, 2'd0);
    n_cmp++;
    if (lt[0] !== 8'h00 || cl[0] !== 8'd0) begin
      n_err++; $display("FAIL clear got %h cnt %0d want 00 cnt 0", lt[0], cl[0]);
    end
    drv(0, 1, 0, 0, 1, 2'b01, 2'd3);
    n_cmp++;
    if (lt[0] !== 8'h40) begin n_err++; $display("FAIL post_clear_no_shift got %h want 40", lt[0]); end
    drv(0, 0, 0, 0, 0, 2'b00, 2'd0);
    drv(0, 1, 0, 0, 0, 2'b00, 2'd0);
    n_cmp++;
    if (lt[0] !== 8'h00 || cl[0] !== 8'd1) begin
      n_err++; $display("FAIL post_clear_exit got %h cnt %0d want 00 cnt 1", lt[0], cl[0]);
    end
    drv(0, 0, 0, 0, 0, 2'b00, 2'd0);
  endtask

  task automatic test_spawn();
    drv(1, 0, 0, 0, 0, 2'b00, 2'd0);
    drv(0, 0, 0, 0, 1, 2'b01, 2'd1);
    drv(0, 1, 0, 0, 1, 2'b10, 2'd2);
    n_cmp++;
    if (lt[0] !== 8'h20) begin n_err++; $display("FAIL spawn_after_shift got %h want 20", lt[0]); end
    drv(0, 0, 0, 0, 1, 2'b11, 2'd2);
    n_cmp++;
    if (lt[0] !== 8'h20) begin n_err++; $display("FAIL spawn_bad_code got %h want 20", lt[0]); end
    drv(0, 0, 0, 0, 1, 2'b00, 2'd2);
    n_cmp++;
    if (lt[0] !== 8'h00) begin n_err++; $display("FAIL spawn_off got %h want 00", lt[0]); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      drv(($urandom_range(0, 49) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
          ($urandom_range(0, 9) == 0), $urandom_range(0, 1),
          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (lt[k] !== mlights(k) || cl[k] !== 8'(mcl[k]) || cr[k] !== 8'(mcr[k])) begin
          n_err++;
          $display("FAIL random c%0d inst%0d got %h %0d/%0d want %h %0d/%0d",
                   c, k, lt[k], cl[k], cr[k], mlights(k), mcl[k], mcr[k]);
        end
      end
    end
  endtask

  initial begin
    reset = 1; mv_left = 0; mv_right = 0; clear = 0;
    spawn_en = 0; spawn_color = 2'b00; spawn_pos = 2'd0;
    test_reset();
    test_single_move();
    test_hold();
    test_wrap();
    test_cancel();
    test_saturate();
    test_clear();
    test_spawn();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
